// File: rtl/alu_arbiter_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_seq_pkg : opcodes and FSM state encoding for alu_arbiter_seq |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_arbiter_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_seq_if : requester, ALU and response signals of the sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface alu_arbiter_seq_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
);
   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic              alu_cin;
   logic              alu_sub;
   logic [DATA_W-1:0] alu_sum;
   logic              alu_cout;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_cout;
   logic              rsp_zero;
   logic              rsp_err;
   logic [CNT_W-1:0]  op_count;

   // The sequencer itself is the slave side.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_sum, alu_cout, rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_op, alu_cin, alu_sub,
      output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero, rsp_err, op_count
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_sum, alu_cout, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_op, alu_cin, alu_sub,
      input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero, rsp_err, op_count
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_seq_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter, valids + pointer -> one-hot grant  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arb2 (
   input  wire logic [1:0] valid,
   input  wire logic       ptr,
   output logic      [1:0] grant
);

   // Pointer only matters under contention; a lone valid is always granted.
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_seq : shares one 8-bit ALU between two requesters, RR order   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_arbiter_seq
   import alu_arbiter_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   alu_arbiter_seq_if.slave bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_ptr;
   logic [1:0]        w_valid;
   logic [1:0]        w_grant;
   logic [1:0]        w_ready;
   logic              w_accept;
   logic              w_legal;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [OP_W-1:0]   r_alu_op;
   logic              r_id;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_cout;
   logic              r_zero;
   logic              r_err;
   logic [CNT_W-1:0]  r_op_count;

   assign w_valid = {bus.req1_valid, bus.req0_valid};

   rr_arb2 u_arb (
      .valid (w_valid),
      .ptr   (r_ptr),
      .grant (w_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Readys are forced low while reset is held so nothing is granted out of reset.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 2'b00;
      case (r_state)
         ST_IDLE: begin
            w_ready = w_grant & {2{rst_n}};
            if (|w_ready) begin
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept = |w_ready;
   assign w_legal  = (r_alu_op == OP_W'(OP_ADD)) || (r_alu_op == OP_W'(OP_SUB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_op   <= '0;
         r_id       <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_cout     <= 1'b0;
         r_zero     <= 1'b0;
         r_err      <= 1'b0;
         r_op_count <= '0;
      end else begin
         if (w_accept) begin
            r_id     <= w_ready[1];
            r_ptr    <= ~w_ready[1];
            r_alu_op <= w_ready[1] ? bus.req1_op : bus.req0_op;
            r_alu_a  <= w_ready[1] ? bus.req1_a  : bus.req0_a;
            r_alu_b  <= w_ready[1] ? bus.req1_b  : bus.req0_b;
         end
         if (r_state == ST_EXEC) begin
            r_valid <= 1'b1;
            if (w_legal) begin
               r_data <= bus.alu_sum;
               r_cout <= bus.alu_cout;
               r_zero <= (bus.alu_sum == '0);
               r_err  <= 1'b0;
            end else begin
               r_data <= '0;
               r_cout <= 1'b0;
               r_zero <= 1'b1;
               r_err  <= 1'b1;
            end
         end
         if ((r_state == ST_RESP) && bus.rsp_ready) begin
            r_valid <= 1'b0;
            if (r_op_count != '1) begin
               r_op_count <= r_op_count + CNT_W'(1);
            end
         end
      end
   end

   assign bus.req0_ready = w_ready[0];
   assign bus.req1_ready = w_ready[1];
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_op     = r_alu_op;
   assign bus.alu_cin    = 1'b0;
   assign bus.alu_sub    = (r_alu_op == OP_W'(OP_SUB));
   assign bus.rsp_valid  = r_valid;
   assign bus.rsp_id     = r_id;
   assign bus.rsp_data   = r_data;
   assign bus.rsp_cout   = r_cout;
   assign bus.rsp_zero   = r_zero;
   assign bus.rsp_err    = r_err;
   assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter_seq : directed self-checking bench for alu_arbiter_seq     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter_seq;
   import alu_arbiter_seq_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   alu_arbiter_seq_if #(.DATA_W(8), .OP_W(4), .CNT_W(16)) bus ();
   alu_arbiter_seq_if #(.DATA_W(8), .OP_W(4), .CNT_W(2))  bus2 ();

   alu_arbiter_seq #(.DATA_W(8), .OP_W(4), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Narrow-counter copy fed the same traffic, to reach saturation quickly.
   alu_arbiter_seq #(.DATA_W(8), .OP_W(4), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   assign bus2.req0_valid = bus.req0_valid;
   assign bus2.req0_op    = bus.req0_op;
   assign bus2.req0_a     = bus.req0_a;
   assign bus2.req0_b     = bus.req0_b;
   assign bus2.req1_valid = bus.req1_valid;
   assign bus2.req1_op    = bus.req1_op;
   assign bus2.req1_a     = bus.req1_a;
   assign bus2.req1_b     = bus.req1_b;
   assign bus2.rsp_ready  = bus.rsp_ready;

   // ALU models: SUB as a + ~b + 1, so carry-out means "no borrow".
   assign {bus.alu_cout, bus.alu_sum} = bus.alu_sub ?
      ({1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1) : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
   assign {bus2.alu_cout, bus2.alu_sum} = bus2.alu_sub ?
      ({1'b0, bus2.alu_a} + {1'b0, ~bus2.alu_b} + 9'd1) : ({1'b0, bus2.alu_a} + {1'b0, bus2.alu_b});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit id, input bit v, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b);
      if (id) begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
   endtask

   task automatic run_op(input bit id, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] e_data, input bit e_cout,
                         input bit e_zero, input bit e_err, input int e_cnt);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      drive(id, 1'b1, op, a, b);
      @(negedge clk);
      check("grant", 32'({bus.req1_ready, bus.req0_ready}), id ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      drive(id, 1'b0, op, a, b);
      @(negedge clk);
      check("exec_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({op, a, b}));
      check("exec_sub", 32'(bus.alu_sub), 32'(op == OP_SUB));
      check("exec_busy", 32'({bus.rsp_valid, bus.req1_ready, bus.req0_ready}), 32'd0);
      @(negedge clk);
      check("rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero, bus.rsp_err}),
            32'({1'b1, id, e_data, e_cout, e_zero, e_err}));
      @(negedge clk);
      check("rsp_clear", 32'(bus.rsp_valid), 32'd0);
      check("count", 32'(bus.op_count), 32'(e_cnt));
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      bus.rsp_ready = 1'b0;
      drive(1'b0, 1'b1, 4'h0, 8'h00, 8'h00);
      drive(1'b1, 1'b1, 4'h0, 8'h00, 8'h00);

      // Reset state, with both valids high
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check("rst_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
      check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero, bus.rsp_err}), 32'd0);
      check("rst_count", 32'(bus.op_count), 32'd0);
      check("alu_cin", 32'(bus.alu_cin), 32'd0);
      drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
      rst_n = 1'b1;

      // Single ops: add, sub to zero, illegal op, add with carry
      run_op(1'b0, OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1);
      run_op(1'b1, OP_SUB, 8'h2A, 8'h2A, 8'h00, 1'b1, 1'b1, 1'b0, 2);
      run_op(1'b0, 4'b0111, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 3);
      run_op(1'b1, OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 4);

      // Backpressure: response held while rsp_ready is low
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      drive(1'b0, 1'b1, OP_ADD, 8'h10, 8'h20);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, OP_ADD, 8'h01, 8'h01);
      @(negedge clk);
      check("bp_exec_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero, bus.rsp_err}),
               32'({1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0}));
         check("bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
         check("bp_count", 32'(bus.op_count), 32'd4);
      end
      bus.rsp_ready = 1'b1;
      drive(1'b0, 1'b0, OP_ADD, 8'h10, 8'h20);
      @(negedge clk);
      check("bp_release", 32'({bus.rsp_valid, bus.req1_ready, bus.req0_ready}), 32'd2);
      check("bp_count_inc", 32'(bus.op_count), 32'd5);
      check("sat_count", 32'(bus2.op_count), 32'd3);
      drive(1'b1, 1'b0, OP_ADD, 8'h01, 8'h01);

      // Reset during EXEC, after req0 moved the pointer to 1
      @(posedge clk); #1;
      drive(1'b0, 1'b1, OP_ADD, 8'h11, 8'h22);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, OP_ADD, 8'h11, 8'h22);
      @(negedge clk);
      check("pre_rst_alu", 32'(bus.alu_a), 32'h11);
      rst_n = 1'b0;
      #1;
      check("mid_rst_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_sub}), 32'd0);
      check("mid_rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero, bus.rsp_err}), 32'd0);
      check("mid_rst_count", 32'({bus.op_count, bus2.op_count}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
      end

      // Contention: grants 0,1,0,1 from a reset pointer, one accept every third cycle
      drive(1'b0, 1'b1, OP_ADD, 8'h01, 8'h01);
      drive(1'b1, 1'b1, OP_ADD, 8'h02, 8'h02);
      for (int k = 0; k < 12; k++) begin
         #1;
         check("rr_ready", 32'({bus.req1_ready, bus.req0_ready}),
               (k % 3 != 0) ? 32'd0 : (((k / 3) % 2 == 1) ? 32'd2 : 32'd1));
         @(negedge clk);
      end
      drive(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01);
      drive(1'b1, 1'b0, OP_ADD, 8'h02, 8'h02);
      check("rr_count", 32'(bus.op_count), 32'd4);
      check("rr_sat_count", 32'(bus2.op_count), 32'd3);
      check("rr_last_id", 32'({bus.rsp_id, bus.rsp_data}), 32'({1'b1, 8'h04}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
